fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Consumer-side companion to the ID/EX pipeline register. It takes that register's outputs (src1, src2, WB_EN, MEM_R_EN, Dest) for the instruction now in EXE.
- It keeps its own shadow copies of the MEM-stage and WB-stage destination info, one and two cycles behind EXE.
- It drives the EXE operand-mux selects for forwarding.
- It raises a load-use stall back to the IF/ID stages and the ID/EX register (via its flush input).

Parameters:
- FWD_EN, 1: 1 enables forwarding. 0 forces selects to 00 and stalls on any RAW hit against EXE or MEM.
- CNT_W, 16: width of the optional stall counter.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_freeze  in  1  memory-stage freeze; shadow pipeline holds when high
- exe_src1  in  4  Rn index of the EXE instruction (ID/EX register src1 output)
- exe_src2  in  4  Rm/Rd index of the EXE instruction (ID/EX register src2 output)
- exe_wb_en  in  1  EXE instruction writes the register file
- exe_mem_r_en  in  1  EXE instruction is a load
- exe_dest  in  4  EXE destination register
- id_src1  in  4  Rn index of the instruction in ID
- id_src2  in  4  second source index of the instruction in ID
- id_two_src  in  1  ID instruction actually reads id_src2
- id_src1_vld  in  1  ID instruction actually reads id_src1
- sel_src1  out  2  EXE Rn mux: 00 regfile, 01 MEM ALU result, 10 WB value
- sel_src2  out  2  EXE Rm mux, same encoding
- stall  out  1  hazard stall: freeze PC and IF/ID, flush ID/EX
- stall_cnt  out  CNT_W  stall cycles counted (only with STALL_CNT_EN)

Behaviour:
- Shadow pipeline registers: mem_wb_en, mem_rd_en, mem_dest, wb_wb_en, wb_dest.
- Reset (rst_n low, async): all shadow registers 0; stall_cnt 0. Outputs settle to sel_src1 = 00, sel_src2 = 00, stall = 0, because all shadow wb_en are 0 and outputs are combinational from regs and inputs.
- Each rising clk with mem_freeze = 0:
  - mem_wb_en/mem_rd_en/mem_dest <= exe_wb_en/exe_mem_r_en/exe_dest.
  - wb_wb_en/wb_dest <= mem_wb_en/mem_dest.
- mem_freeze = 1: all shadow registers hold.
- stall has no effect on the shadow update. The EXE instruction still advances; the bubble arrives via the flushed ID/EX inputs the following cycle.
- Forward select (FWD_EN = 1), combinational, zero latency, for each of src1/src2:
  - 01 if mem_wb_en and mem_dest == exe_srcX and not mem_rd_en;
  - else 10 if wb_wb_en and wb_dest == exe_srcX;
  - else 00.
  - MEM has priority over WB when both match (youngest producer wins).
  - A load in MEM is never forwarded from MEM; the stall guarantees it has reached WB before the consumer is in EXE.
- Stall (FWD_EN = 1): stall = exe_wb_en & exe_mem_r_en & ((id_src1_vld & id_src1 == exe_dest) | (id_two_src & id_src2 == exe_dest)).
  - Exactly one cycle per load-use pair: after the flush, EXE holds a bubble (wb_en = 0), so stall drops by itself.
- Stall (FWD_EN = 0): stall on a RAW hit against EXE (exe_wb_en) or MEM (mem_wb_en), whether or not the producer is a load.
  - A dependency on an ALU op in EXE gives 2 stall cycles; selects are constant 00.
- No matching against register 15; PC reads are resolved in ID.
- Simultaneous stall and mem_freeze: stall stays asserted as computed; shadow pipeline holds.
- rst_n asserted mid-stall: stall deasserts immediately (async); no partial state survives.

Optional Feature:
- Macro STALL_CNT_EN.
- Defined: stall_cnt increments by 1 on each rising clk where stall = 1 and mem_freeze = 0. It saturates at all-ones and is cleared only by reset.
- Not defined: stall_cnt is tied to 0 and no counter flops exist.

Test Plan:
- ALU producer, immediate consumer:
  - Stimulus: ADD R1 in EXE (exe_wb_en = 1, exe_dest = 1); next cycle the consumer in EXE has exe_src1 = 1.
  - Required: sel_src1 = 01, stall = 0.
- Two-back producer:
  - Stimulus: writer of R2, one independent instruction, then consumer with exe_src2 = 2.
  - Required: sel_src2 = 10.
- Load-use:
  - Stimulus: LDR R3 in EXE (exe_mem_r_en = 1, exe_dest = 3), ID has id_src1 = 3, id_src1_vld = 1.
  - Required: stall = 1 for exactly one cycle; then the consumer in EXE gets sel_src1 = 10.
  - With STALL_CNT_EN defined: stall_cnt = 1.
- MEM/WB double match:
  - Stimulus: R4 written in both MEM and WB; exe_src1 = 4.
  - Required: sel_src1 = 01.
  - Repeat with id_two_src = 0, id_src2 = 3 against a load of R3: stall = 0.
- Freeze and reset:
  - Stimulus: hold mem_freeze = 1 for 3 cycles with a writer of R5 in MEM.
  - Required: sel for exe_src1 = 5 stays 01 throughout.
  - Then pull rst_n low asynchronously mid-cycle: selects go to 00 and stall to 0 before the next edge; stall_cnt = 0.
- FWD_EN = 0:
  - Stimulus: ALU writer of R6 in EXE, ID reads R6.
  - Required: stall = 1 for 2 consecutive cycles; selects always 00.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// rtl/fwd_hazard_unit.sv - EXE operand forwarding selects and load-use stall with MEM/WB shadow pipeline
//
// Sits beside the ID/EX register and keeps shadow copies of the MEM and WB stage
// destination info (one and two cycles behind EXE).
//
// Parameters:
//   FWD_EN - 1: forward from MEM/WB, stall only on load-use.
//            0: selects fixed at regfile, stall on any RAW hit against EXE or MEM.
//   CNT_W  - width of the stall counter.
// Optional feature macro: STALL_CNT_EN (stall cycle counter; tied to 0 when undefined).
//
// Ports:
//   clk, rst_n                 - clock (rising edge), asynchronous active-low reset
//   mem_freeze                 - holds the shadow pipeline
//   exe_src1/exe_src2          - source indices of the EXE instruction
//   exe_wb_en/exe_mem_r_en     - EXE instruction writes regfile / is a load
//   exe_dest                   - EXE destination register
//   id_src1/id_src1_vld        - first source of the ID instruction and its valid
//   id_src2/id_two_src         - second source of the ID instruction and its valid
//   sel_src1/sel_src2          - EXE operand muxes: 00 regfile, 01 MEM, 10 WB
//   stall                      - freeze PC and IF/ID, flush ID/EX
//   stall_cnt                  - stall cycles counted

module fwd_hazard_unit #(
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_freeze,
    input  logic [3:0]       exe_src1,
    input  logic [3:0]       exe_src2,
    input  logic             exe_wb_en,
    input  logic             exe_mem_r_en,
    input  logic [3:0]       exe_dest,
    input  logic [3:0]       id_src1,
    input  logic [3:0]       id_src2,
    input  logic             id_two_src,
    input  logic             id_src1_vld,
    output logic [1:0]       sel_src1,
    output logic [1:0]       sel_src2,
    output logic             stall,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_MEM = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;
    // The PC is read in ID, so R15 never takes part in hazard matching.
    localparam logic [3:0] REG_PC  = 4'd15;

    logic       mem_wb_en_q, mem_wb_en_d;
    logic       mem_rd_en_q, mem_rd_en_d;
    logic [3:0] mem_dest_q,  mem_dest_d;
    logic       wb_wb_en_q,  wb_wb_en_d;
    logic [3:0] wb_dest_q,   wb_dest_d;
    logic       stall_raw;

    function automatic logic [1:0] fwd_sel(
        input logic [3:0] src,
        input logic       m_wb,
        input logic       m_rd,
        input logic [3:0] m_dest,
        input logic       w_wb,
        input logic [3:0] w_dest
    );
        logic [1:0] sel;
        sel = SEL_RF;
        if (src != REG_PC) begin
            // A load in MEM has no data yet; the load-use stall makes sure it
            // is already in WB by the time its consumer reaches EXE.
            if (m_wb && !m_rd && m_dest == src) begin
                sel = SEL_MEM;
            end else if (w_wb && w_dest == src) begin
                sel = SEL_WB;
            end
        end
        return sel;
    endfunction

    function automatic logic id_reads(
        input logic [3:0] dest,
        input logic       s1_vld,
        input logic [3:0] s1,
        input logic       two,
        input logic [3:0] s2
    );
        return (dest != REG_PC) && ((s1_vld && s1 == dest) || (two && s2 == dest));
    endfunction

    always_comb begin
        mem_wb_en_d = mem_wb_en_q;
        mem_rd_en_d = mem_rd_en_q;
        mem_dest_d  = mem_dest_q;
        wb_wb_en_d  = wb_wb_en_q;
        wb_dest_d   = wb_dest_q;
        // The EXE instruction advances even while stalling; the bubble comes
        // in through the flushed ID/EX register one cycle later.
        if (!mem_freeze) begin
            mem_wb_en_d = exe_wb_en;
            mem_rd_en_d = exe_mem_r_en;
            mem_dest_d  = exe_dest;
            wb_wb_en_d  = mem_wb_en_q;
            wb_dest_d   = mem_dest_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wb_en_q <= 1'b0;
            mem_rd_en_q <= 1'b0;
            mem_dest_q  <= 4'd0;
            wb_wb_en_q  <= 1'b0;
            wb_dest_q   <= 4'd0;
        end else begin
            mem_wb_en_q <= mem_wb_en_d;
            mem_rd_en_q <= mem_rd_en_d;
            mem_dest_q  <= mem_dest_d;
            wb_wb_en_q  <= wb_wb_en_d;
            wb_dest_q   <= wb_dest_d;
        end
    end

    always_comb begin
        sel_src1  = SEL_RF;
        sel_src2  = SEL_RF;
        stall_raw = 1'b0;
        if (FWD_EN != 0) begin
            sel_src1  = fwd_sel(exe_src1, mem_wb_en_q, mem_rd_en_q, mem_dest_q,
                                wb_wb_en_q, wb_dest_q);
            sel_src2  = fwd_sel(exe_src2, mem_wb_en_q, mem_rd_en_q, mem_dest_q,
                                wb_wb_en_q, wb_dest_q);
            stall_raw = exe_wb_en && exe_mem_r_en &&
                        id_reads(exe_dest, id_src1_vld, id_src1, id_two_src, id_src2);
        end else begin
            // Without forwarding the consumer waits until the producer is in WB.
            stall_raw = (exe_wb_en &&
                         id_reads(exe_dest, id_src1_vld, id_src1, id_two_src, id_src2)) ||
                        (mem_wb_en_q &&
                         id_reads(mem_dest_q, id_src1_vld, id_src1, id_two_src, id_src2));
        end
    end

    // The stall term depends directly on inputs, so reset must mask it explicitly.
    assign stall = rst_n && stall_raw;

`ifdef STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall && !mem_freeze && stall_cnt_q != {CNT_W{1'b1}}) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb/tb_fwd_hazard_unit.sv - table, hand sequences and random check of fwd_hazard_unit (FWD_EN 1 and 0)

module tb_fwd_hazard_unit;

    typedef struct {
        logic       frz;
        logic       ewb;
        logic       eld;
        logic [3:0] ed;
        logic [3:0] es1;
        logic [3:0] es2;
        logic [3:0] is1;
        logic       ivld;
        logic [3:0] is2;
        logic       itwo;
    } vin_t;

    typedef struct {
        vin_t       v;
        logic [1:0] s1;
        logic [1:0] s2;
        logic       st;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_freeze;
    logic [3:0]  exe_src1, exe_src2, exe_dest, id_src1, id_src2;
    logic        exe_wb_en, exe_mem_r_en, id_two_src, id_src1_vld;
    logic [1:0]  s1_f, s2_f, s1_n, s2_n;
    logic        st_f, st_n;
    logic [15:0] cnt_f, cnt_n;

    int n_vec = 0;
    int n_bad = 0;

    // Reference history: index 1 is the instruction one cycle older than EXE, 2 is two older.
    logic       h_wb   [1:2];
    logic       h_ld   [1:2];
    logic [3:0] h_dest [1:2];
    int         m_cnt_f;
    int         m_cnt_n;

    vec_t tbl[$];

    always #5 clk = ~clk;

    fwd_hazard_unit #(.FWD_EN(1), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .mem_freeze(mem_freeze),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_src1_vld(id_src1_vld),
        .sel_src1(s1_f), .sel_src2(s2_f), .stall(st_f), .stall_cnt(cnt_f)
    );

    fwd_hazard_unit #(.FWD_EN(0), .CNT_W(16)) dut_nf (
        .clk(clk), .rst_n(rst_n), .mem_freeze(mem_freeze),
        .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_wb_en(exe_wb_en),
        .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
        .id_src1(id_src1), .id_src2(id_src2), .id_two_src(id_two_src),
        .id_src1_vld(id_src1_vld),
        .sel_src1(s1_n), .sel_src2(s2_n), .stall(st_n), .stall_cnt(cnt_n)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vin_t mk(input logic frz, input logic ewb, input logic eld,
                                input logic [3:0] ed, input logic [3:0] es1,
                                input logic [3:0] es2, input logic [3:0] is1,
                                input logic ivld, input logic [3:0] is2, input logic itwo);
        vin_t v;
        v.frz = frz; v.ewb = ewb; v.eld = eld; v.ed = ed; v.es1 = es1; v.es2 = es2;
        v.is1 = is1; v.ivld = ivld; v.is2 = is2; v.itwo = itwo;
        return v;
    endfunction

    task automatic add(input vin_t v, input logic [1:0] s1, input logic [1:0] s2, input logic st);
        vec_t r;
        r.v = v; r.s1 = s1; r.s2 = s2; r.st = st;
        tbl.push_back(r);
    endtask

    function automatic logic [15:0] cexp(input int c);
`ifdef STALL_CNT_EN
        return (c > 65535) ? 16'hffff : 16'(c);
`else
        return (c < 0) ? 16'd1 : 16'd0;
`endif
    endfunction

    // Youngest eligible older writer of src supplies the operand; a load only once it is in WB.
    function automatic logic [1:0] m_sel(input logic [3:0] src);
        logic [1:0] r;
        r = 2'b00;
        for (int d = 2; d >= 1; d--) begin
            if (src != 4'd15 && h_wb[d] && h_dest[d] == src && !(d == 1 && h_ld[d]))
                r = 2'(d);
        end
        return r;
    endfunction

    function automatic logic m_reads(input vin_t v, input logic [3:0] r);
        return r != 4'd15 && ((v.ivld && v.is1 == r) || (v.itwo && v.is2 == r));
    endfunction

    function automatic logic m_stall_f(input vin_t v);
        return v.ewb && v.eld && m_reads(v, v.ed);
    endfunction

    // Without forwarding, any writer not yet in WB (EXE or MEM) blocks the reader in ID.
    function automatic logic m_stall_n(input vin_t v);
        logic        wb  [0:1];
        logic [3:0]  dst [0:1];
        logic        s;
        wb[0] = v.ewb;   dst[0] = v.ed;
        wb[1] = h_wb[1]; dst[1] = h_dest[1];
        s = 1'b0;
        for (int d = 0; d <= 1; d++) if (wb[d] && m_reads(v, dst[d])) s = 1'b1;
        return s;
    endfunction

    task automatic model_clear();
        for (int d = 1; d <= 2; d++) begin
            h_wb[d] = 1'b0; h_ld[d] = 1'b0; h_dest[d] = 4'd0;
        end
        m_cnt_f = 0;
        m_cnt_n = 0;
    endtask

    task automatic drive(input vin_t v);
        mem_freeze = v.frz; exe_wb_en = v.ewb; exe_mem_r_en = v.eld; exe_dest = v.ed;
        exe_src1 = v.es1; exe_src2 = v.es2; id_src1 = v.is1; id_src1_vld = v.ivld;
        id_src2 = v.is2; id_two_src = v.itwo;
    endtask

    // One clock: drive at negedge, compare just after, then advance the model to the next posedge.
    task automatic cyc(input vin_t v);
        logic [1:0] e1, e2;
        logic       ef, en;
        @(negedge clk);
        drive(v);
        #1;
        e1 = m_sel(v.es1);
        e2 = m_sel(v.es2);
        ef = m_stall_f(v);
        en = m_stall_n(v);
        chk("sel_src1", 32'(s1_f), 32'(e1));
        chk("sel_src2", 32'(s2_f), 32'(e2));
        chk("stall", 32'(st_f), 32'(ef));
        chk("stall_cnt", 32'(cnt_f), 32'(cexp(m_cnt_f)));
        chk("nf_sel_src1", 32'(s1_n), 32'd0);
        chk("nf_sel_src2", 32'(s2_n), 32'd0);
        chk("nf_stall", 32'(st_n), 32'(en));
        chk("nf_stall_cnt", 32'(cnt_n), 32'(cexp(m_cnt_n)));
        if (!v.frz) begin
            if (ef) m_cnt_f++;
            if (en) m_cnt_n++;
            h_wb[2] = h_wb[1]; h_ld[2] = h_ld[1]; h_dest[2] = h_dest[1];
            h_wb[1] = v.ewb;   h_ld[1] = v.eld;   h_dest[1] = v.ed;
        end
    endtask

    function automatic logic [3:0] rnd_reg();
        int r;
        r = $urandom_range(0, 5);
        return (r == 5) ? 4'd15 : 4'(r);
    endfunction

    initial begin
        int c0;
        vin_t z;
        vin_t lu;
        z  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        lu = mk(0, 1, 1, 3, 0, 0, 3, 1, 0, 0);

        // Reset: load-use pattern on the inputs must still give stall = 0.
        rst_n = 1'b0;
        drive(lu);
        model_clear();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sel_src1", 32'(s1_f), 32'd0);
        chk("rst_sel_src2", 32'(s2_f), 32'd0);
        chk("rst_stall", 32'(st_f), 32'd0);
        chk("rst_nf_stall", 32'(st_n), 32'd0);
        chk("rst_stall_cnt", 32'(cnt_f), 32'd0);
        @(negedge clk);
        drive(z);
        rst_n = 1'b1;

        add(mk(0, 0, 0, 0,  0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0);
        add(mk(0, 1, 0, 1,  0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0);  // ADD R1
        add(mk(0, 0, 0, 0,  1, 0, 0, 0, 0, 0), 2'b01, 2'b00, 1'b0);  // reads R1 from MEM
        add(mk(0, 1, 0, 2,  1, 0, 0, 0, 0, 0), 2'b10, 2'b00, 1'b0);  // writer R2, R1 now in WB
        add(mk(0, 1, 0, 7,  0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0);  // independent
        add(mk(0, 0, 0, 0,  0, 2, 0, 0, 0, 0), 2'b00, 2'b10, 1'b0);  // two-back R2
        add(mk(0, 1, 1, 3,  0, 0, 3, 1, 0, 0), 2'b00, 2'b00, 1'b1);  // LDR R3, ID reads R3
        add(mk(0, 0, 0, 0,  3, 0, 3, 1, 0, 0), 2'b00, 2'b00, 1'b0);  // bubble; load in MEM not forwarded
        add(mk(0, 1, 0, 8,  3, 0, 0, 0, 0, 0), 2'b10, 2'b00, 1'b0);  // consumer gets load from WB
        add(mk(0, 1, 0, 4,  0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0);  // writer R4
        add(mk(0, 1, 0, 4,  0, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0);  // writer R4 again
        add(mk(0, 1, 1, 3,  4, 4, 5, 1, 3, 0), 2'b01, 2'b01, 1'b0);  // MEM beats WB; id_two_src=0
        add(mk(0, 1, 1, 15, 15, 0, 15, 1, 0, 0), 2'b00, 2'b00, 1'b0); // R15 load-use ignored
        add(mk(0, 0, 0, 0,  15, 3, 0, 0, 0, 0), 2'b00, 2'b10, 1'b0);
        add(mk(0, 1, 0, 15, 15, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0); // R15 in WB ignored
        add(mk(0, 1, 0, 5,  15, 0, 0, 0, 0, 0), 2'b00, 2'b00, 1'b0); // R15 in MEM ignored
        add(mk(1, 1, 0, 9,  5, 0, 0, 0, 0, 0), 2'b01, 2'b00, 1'b0);  // freeze x3, R5 held in MEM
        add(mk(1, 1, 0, 9,  5, 0, 0, 0, 0, 0), 2'b01, 2'b00, 1'b0);
        add(mk(1, 1, 0, 9,  5, 0, 0, 0, 0, 0), 2'b01, 2'b00, 1'b0);
        add(mk(0, 1, 0, 9,  5, 0, 0, 0, 0, 0), 2'b01, 2'b00, 1'b0);
        add(mk(0, 0, 0, 0,  5, 9, 0, 0, 0, 0), 2'b10, 2'b01, 1'b0);

        foreach (tbl[i]) begin
            cyc(tbl[i].v);
            chk($sformatf("tbl%0d_sel_src1", i), 32'(s1_f), 32'(tbl[i].s1));
            chk($sformatf("tbl%0d_sel_src2", i), 32'(s2_f), 32'(tbl[i].s2));
            chk($sformatf("tbl%0d_stall", i), 32'(st_f), 32'(tbl[i].st));
        end

        // Stall during freeze: stays asserted, counts only on the unfrozen edge.
        c0 = m_cnt_f;
        cyc(mk(1, 1, 1, 3, 0, 0, 3, 1, 0, 0));
        chk("frz_stall_a", 32'(st_f), 32'd1);
        cyc(mk(1, 1, 1, 3, 0, 0, 3, 1, 0, 0));
        chk("frz_stall_b", 32'(st_f), 32'd1);
        cyc(lu);
        chk("frz_stall_c", 32'(st_f), 32'd1);
        cyc(mk(0, 0, 0, 0, 0, 0, 3, 1, 0, 0));
        chk("frz_stall_drop", 32'(st_f), 32'd0);
        chk("frz_stall_cnt", 32'(cnt_f), 32'(cexp(c0 + 1)));

        // No forwarding: ALU writer of R6 with a reader in ID gives two stall cycles.
        cyc(z);
        cyc(z);
        cyc(mk(0, 1, 0, 6, 0, 0, 6, 1, 0, 0));
        chk("nf_stall_1", 32'(st_n), 32'd1);
        chk("nf_fwd_no_stall", 32'(st_f), 32'd0);
        cyc(mk(0, 0, 0, 0, 0, 0, 6, 1, 0, 0));
        chk("nf_stall_2", 32'(st_n), 32'd1);
        cyc(mk(0, 0, 0, 0, 6, 0, 0, 0, 0, 0));
        chk("nf_stall_3", 32'(st_n), 32'd0);
        chk("nf_sel_hold", 32'(s1_n), 32'd0);

        // Asynchronous reset in the middle of a stalling cycle.
        cyc(mk(0, 1, 0, 5, 0, 0, 0, 0, 0, 0));
        cyc(mk(0, 1, 1, 3, 5, 0, 3, 1, 0, 0));
        chk("pre_rst_sel", 32'(s1_f), 32'd1);
        chk("pre_rst_stall", 32'(st_f), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_sel_src1", 32'(s1_f), 32'd0);
        chk("async_rst_stall", 32'(st_f), 32'd0);
        chk("async_rst_nf_stall", 32'(st_n), 32'd0);
        chk("async_rst_cnt", 32'(cnt_f), 32'd0);
        chk("async_rst_nf_cnt", 32'(cnt_n), 32'd0);
        @(negedge clk);
        drive(z);
        rst_n = 1'b1;
        model_clear();

        for (int k = 0; k < 3000; k++) begin
            vin_t v;
            v.frz  = ($urandom_range(0, 7) == 0);
            v.ewb  = 1'($urandom_range(0, 1));
            v.eld  = ($urandom_range(0, 2) == 0);
            v.ed   = rnd_reg();
            v.es1  = rnd_reg();
            v.es2  = rnd_reg();
            v.is1  = rnd_reg();
            v.ivld = 1'($urandom_range(0, 1));
            v.is2  = rnd_reg();
            v.itwo = 1'($urandom_range(0, 1));
            cyc(v);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
